// File: rtl/maria_regfile_v2.sv
// MARIA register window decode, register file, double-buffered CTRL, colour RAM and WSYNC handshake.
// Define MARIA_REGFILE_READBACK_EN to make the writable registers and colour entries readable.
module maria_regfile_v2 #(
   parameter int          NUM_PALETTES   = 8,
   parameter logic [15:0] WIN_BASE       = 16'h0020,
   parameter logic [15:0] MIRROR_MASK    = 16'h0300,
   parameter logic [15:0] ZP_BYPASS_NTSC = 16'h0084,
   parameter logic [15:0] ZP_BYPASS_PAL  = 16'h2730
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        mclk0,
   input  logic        pclkp,
   input  logic        maria_en,
   input  logic [15:0] AB,
   input  logic [7:0]  DB_in,
   input  logic        RW,
   input  logic        ABEN,
   input  logic        bypass_bios,
   input  logic        pal,
   input  logic [7:0]  status_read,
   input  logic        line_start,
   input  logic [4:0]  pal_idx,
   output logic [7:0]  pal_data,
   output logic        cs_maria,
   output logic [7:0]  DB_out,
   output logic [7:0]  ctrl,
   output logic [7:0]  char_base,
   output logic [15:0] ZP,
   output logic        wsync
);

   localparam int DEPTH = 1 + 3 * NUM_PALETTES;
   localparam int SLOTS = 32;

   typedef enum logic {WS_IDLE, WS_WAIT} ws_state_t;

   logic        blk_rst;
   logic [15:0] ab_masked;
   logic [4:0]  off;
   logic        old_phase;
   logic        acc, wr, rd;
   logic        wr_wsync, wr_ctrl;
   logic        col_hit;
   logic [4:0]  col_idx;
   logic [7:0]  rd_data;
   logic [7:0]  ctrl_pend;
   logic [7:0]  zp_h, zp_l;
   logic [15:0] zp_rst;
   logic [7:0]  ram [SLOTS];
   ws_state_t   ws_state, ws_state_nx;

   assign blk_rst   = reset | ~maria_en;
   assign ab_masked = AB & ~MIRROR_MASK;
   assign off       = AB[4:0];
   assign cs_maria  = (ab_masked[15:5] == WIN_BASE[15:5]) && !ABEN && maria_en;

   // One strobe per CPU phase: the 0->1 edge of pclkp as sampled on mclk0.
   assign acc      = cs_maria && pclkp && !old_phase && mclk0;
   assign wr       = acc && !RW;
   assign rd       = acc && RW;
   assign wr_wsync = wr && (off == 5'h04);
   assign wr_ctrl  = wr && (off == 5'h1C);

   assign zp_rst = bypass_bios ? (pal ? ZP_BYPASS_PAL : ZP_BYPASS_NTSC) : 16'h0000;
   assign ZP     = {zp_h, zp_l};

   // Offset 0 is the background colour; o[1:0]=1..3 picks colour 1..3 of palette o[4:2],
   // so the flat entry is 1 + 3*o[4:2] + (o[1:0]-1), which simplifies to 3*o[4:2] + o[1:0].
   always_comb begin
      col_hit = 1'b0;
      col_idx = 5'd0;
      if (off == 5'h00) begin
         col_hit = 1'b1;
      end else if (off[1:0] != 2'b00 && int'(off[4:2]) < NUM_PALETTES) begin
         col_hit = 1'b1;
         col_idx = 5'd3 * {2'b00, off[4:2]} + {3'b000, off[1:0]};
      end
   end

`ifdef MARIA_REGFILE_READBACK_EN
   always_comb begin
      rd_data = 8'h00;
      case (off)
         5'h08:   rd_data = status_read;
         5'h0C:   rd_data = zp_h;
         5'h10:   rd_data = zp_l;
         5'h14:   rd_data = char_base;
         5'h1C:   rd_data = ctrl_pend;
         default: if (col_hit) rd_data = ram[col_idx];
      endcase
   end
`else
   always_comb begin
      rd_data = (off == 5'h08) ? status_read : 8'h00;
   end
`endif

   // NOTE: the colour RAM is a flop array rather than a memory macro, because it must
   // clear on reset; entries beyond DEPTH are never written and trim away as constants.
   always_ff @(posedge clk_sys) begin
      if (blk_rst) begin
         old_phase <= 1'b0;
         ctrl      <= 8'hFF;
         ctrl_pend <= 8'hFF;
         char_base <= 8'h00;
         zp_h      <= zp_rst[15:8];
         zp_l      <= zp_rst[7:0];
         DB_out    <= 8'h00;
         pal_data  <= 8'h00;
         for (int i = 0; i < SLOTS; i++) ram[i] <= 8'h00;
      end else begin
         if (mclk0) old_phase <= pclkp;

         if (wr) begin
            case (off)
               5'h0C:   zp_h      <= DB_in;
               5'h10:   zp_l      <= DB_in;
               5'h14:   char_base <= DB_in;
               5'h1C:   ctrl_pend <= DB_in;
               default: if (col_hit) ram[col_idx] <= DB_in;
            endcase
         end

         // A CTRL write in this cycle defers the commit to the next mclk0.
         if (mclk0 && !wr_ctrl) ctrl <= ctrl_pend;

         if (rd) DB_out <= rd_data;

         // NOTE: non-blocking assignment here gives the old entry on a same-cycle write.
         pal_data <= (int'(pal_idx) < DEPTH) ? ram[pal_idx] : 8'h00;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (blk_rst) ws_state <= WS_IDLE;
      else         ws_state <= ws_state_nx;
   end

   // A fresh WSYNC request wins over a coincident line_start.
   always_comb begin
      ws_state_nx = ws_state;
      case (ws_state)
         WS_IDLE: if (wr_wsync) ws_state_nx = WS_WAIT;
         WS_WAIT: if (!wr_wsync && line_start) ws_state_nx = WS_IDLE;
         default: ws_state_nx = WS_IDLE;
      endcase
   end

   always_comb begin
      wsync = (ws_state == WS_WAIT) && !blk_rst;
   end

endmodule

// File: tb/tb_maria_regfile_v2.sv
// Directed bench for maria_regfile_v2 (NUM_PALETTES=2) with an expected-value scoreboard queue.
// Honours MARIA_REGFILE_READBACK_EN for the readback expectation.
module tb_maria_regfile_v2;

   logic        clk_sys = 1'b0;
   logic        reset, mclk0, pclkp, maria_en;
   logic [15:0] AB;
   logic [7:0]  DB_in;
   logic        RW, ABEN, bypass_bios, pal;
   logic [7:0]  status_read;
   logic        line_start;
   logic [4:0]  pal_idx;
   logic [7:0]  pal_data, DB_out, ctrl, char_base;
   logic        cs_maria, wsync;
   logic [15:0] ZP;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_sys = ~clk_sys;

   maria_regfile_v2 #(.NUM_PALETTES(2)) dut (
      .clk_sys(clk_sys), .reset(reset), .mclk0(mclk0), .pclkp(pclkp),
      .maria_en(maria_en), .AB(AB), .DB_in(DB_in), .RW(RW), .ABEN(ABEN),
      .bypass_bios(bypass_bios), .pal(pal), .status_read(status_read),
      .line_start(line_start), .pal_idx(pal_idx), .pal_data(pal_data),
      .cs_maria(cs_maria), .DB_out(DB_out), .ctrl(ctrl), .char_base(char_base),
      .ZP(ZP), .wsync(wsync)
   );

   task automatic expect_v(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [15:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_underflow observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick(input logic m);
      mclk0 = m;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic cpu_access(input logic [15:0] addr, input logic [7:0] data,
                             input logic rw, input logic ls);
      AB    = addr;
      DB_in = data;
      RW    = rw;
      pclkp = 1'b0;
      tick(1'b1);
      pclkp      = 1'b1;
      line_start = ls;
      tick(1'b1);
      line_start = 1'b0;
   endtask

   task automatic bus_idle();
      AB    = 16'h0000;
      RW    = 1'b1;
      pclkp = 1'b0;
      tick(1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mclk0 = 1'b0; pclkp = 1'b0; maria_en = 1'b1;
      AB = 16'h0000; DB_in = 8'h00; RW = 1'b1; ABEN = 1'b0;
      bypass_bios = 1'b1; pal = 1'b1; status_read = 8'h00;
      line_start = 1'b0; pal_idx = 5'd0;
      tick(1'b1);
      tick(1'b1);

      expect_v("rst_zp_pal", 16'h2730);  check(ZP);
      expect_v("rst_ctrl", 16'h00FF);    check(ctrl);
      expect_v("rst_charbase", 16'h0);   check(char_base);
      expect_v("rst_dbout", 16'h0);      check(DB_out);
      expect_v("rst_wsync", 16'h0);      check(wsync);
      expect_v("rst_paldata", 16'h0);    check(pal_data);

      pal = 1'b0;
      tick(1'b1);
      expect_v("rst_zp_ntsc", 16'h0084); check(ZP);

      bypass_bios = 1'b0;
      tick(1'b1);
      expect_v("rst_zp_nobypass", 16'h0000); check(ZP);
      reset = 1'b0;
      bus_idle();

      // CTRL double buffering: commit on the mclk0 after the write strobe
      expect_v("ctrl_write_cycle", 16'h00FF);
      cpu_access(16'h003C, 8'h55, 1'b0, 1'b0);
      check(ctrl);
      expect_v("ctrl_no_mclk0", 16'h00FF);
      tick(1'b0);
      check(ctrl);
      expect_v("ctrl_commit", 16'h0055);
      tick(1'b1);
      check(ctrl);

      // pclkp held high across many mclk0 cycles takes one access only
      expect_v("charbase_single_access", 16'h0077);
      cpu_access(16'h0034, 8'h77, 1'b0, 1'b0);
      DB_in = 8'h99;
      repeat (5) tick(1'b1);
      check(char_base);
      bus_idle();

      // colour RAM: entry 1, entry 6, dropped palette 4, background through a mirror
      cpu_access(16'h0021, 8'hA1, 1'b0, 1'b0);
      cpu_access(16'h0027, 8'hB7, 1'b0, 1'b0);
      cpu_access(16'h0031, 8'hCC, 1'b0, 1'b0);
      cpu_access(16'h0220, 8'h3E, 1'b0, 1'b0);
      bus_idle();
      pal_idx = 5'd1;  expect_v("pal_entry1", 16'h00A1);
      tick(1'b0);      check(pal_data);
      pal_idx = 5'd6;  expect_v("pal_entry6", 16'h00B7);
      tick(1'b0);      check(pal_data);
      pal_idx = 5'd13; expect_v("pal_out_of_depth", 16'h0000);
      tick(1'b0);      check(pal_data);
      pal_idx = 5'd0;  expect_v("pal_background", 16'h003E);
      tick(1'b0);      check(pal_data);
      pal_idx = 5'd4;  expect_v("pal_entry4_untouched", 16'h0000);
      tick(1'b0);      check(pal_data);

      // same-cycle write and read of one entry returns the old value
      pal_idx = 5'd1;
      expect_v("pal_rdw_old", 16'h00A1);
      cpu_access(16'h0021, 8'hD2, 1'b0, 1'b0);
      check(pal_data);
      expect_v("pal_rdw_new", 16'h00D2);
      tick(1'b0);
      check(pal_data);
      bus_idle();

      // WSYNC handshake
      expect_v("wsync_idle", 16'h0);
      check(wsync);
      expect_v("wsync_set", 16'h1);
      cpu_access(16'h0024, 8'h00, 1'b0, 1'b0);
      check(wsync);
      expect_v("wsync_hold", 16'h1);
      repeat (5) tick(1'b0);
      check(wsync);
      expect_v("wsync_release", 16'h0);
      line_start = 1'b1;
      tick(1'b0);
      line_start = 1'b0;
      check(wsync);
      expect_v("wsync_ls_idle", 16'h0);
      line_start = 1'b1;
      tick(1'b0);
      line_start = 1'b0;
      check(wsync);
      bus_idle();
      cpu_access(16'h0024, 8'h00, 1'b0, 1'b0);
      bus_idle();
      expect_v("wsync_coincident_keep", 16'h1);
      cpu_access(16'h0024, 8'h00, 1'b0, 1'b1);
      check(wsync);
      bus_idle();
      expect_v("wsync_clear_after", 16'h0);
      line_start = 1'b1;
      tick(1'b0);
      line_start = 1'b0;
      check(wsync);

      // ZP writes and reads
      cpu_access(16'h002C, 8'h12, 1'b0, 1'b0);
      cpu_access(16'h0030, 8'h34, 1'b0, 1'b0);
      bus_idle();
      expect_v("zp_written", 16'h1234);
      check(ZP);

      status_read = 8'h80;
      expect_v("read_mstat_mirror", 16'h0080);
      cpu_access(16'h0128, 8'h00, 1'b1, 1'b0);
      check(DB_out);
`ifdef MARIA_REGFILE_READBACK_EN
      expect_v("read_zph", 16'h0012);
`else
      expect_v("read_zph", 16'h0000);
`endif
      cpu_access(16'h002C, 8'h00, 1'b1, 1'b0);
      check(DB_out);
      bus_idle();
      status_read = 8'h00;
`ifdef MARIA_REGFILE_READBACK_EN
      expect_v("dbout_holds", 16'h0012);
`else
      expect_v("dbout_holds", 16'h0000);
`endif
      check(DB_out);

      // ABEN suppresses decode
      ABEN = 1'b1;
      AB   = 16'h0030;
      #1;
      expect_v("cs_aben", 16'h0);
      check(cs_maria);
      cpu_access(16'h0030, 8'hEE, 1'b0, 1'b0);
      expect_v("zp_aben_unchanged", 16'h1234);
      check(ZP);
      ABEN = 1'b0;
      AB   = 16'h0330;
      #1;
      expect_v("cs_mirror_hit", 16'h1);
      check(cs_maria);
      AB = 16'h0040;
      #1;
      expect_v("cs_outside", 16'h0);
      check(cs_maria);
      bus_idle();

      // reset mid-WAIT drops wsync in the reset cycle
      expect_v("wsync_before_rst", 16'h1);
      cpu_access(16'h0024, 8'h00, 1'b0, 1'b0);
      check(wsync);
      reset = 1'b1;
      #1;
      expect_v("wsync_rst_same_cycle", 16'h0);
      check(wsync);
      tick(1'b1);
      reset = 1'b0;
      expect_v("ctrl_after_rst", 16'h00FF);
      check(ctrl);
      bus_idle();

      // maria_en=0 holds the block in reset
      cpu_access(16'h003C, 8'h42, 1'b0, 1'b0);
      bus_idle();
      expect_v("ctrl_before_disable", 16'h0042);
      check(ctrl);
      maria_en = 1'b0;
      AB = 16'h003C;
      #1;
      expect_v("cs_disabled", 16'h0);
      check(cs_maria);
      tick(1'b1);
      expect_v("ctrl_disabled", 16'h00FF);
      check(ctrl);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/maria_regfile_v2.md
Name: maria_regfile_v2

Overview:
- Parametrised successor to the MARIA register/decode logic.
- Decodes CPU accesses to the MARIA register window and holds these registers:
  - ZP (display-list-list pointer)
  - CHARBASE
  - CTRL, double-buffered and committed on mclk0
  - a configurable-depth colour RAM, exposed through a registered read port instead of a flat array
- Adds a WSYNC handshake with the line timer.
- Sits between the CPU bus interface and the MARIA DMA/video pipeline.

Parameters:
- NUM_PALETTES, 8, number of 3-colour palettes implemented (1..8); colour RAM depth is 1 + 3*NUM_PALETTES.
- WIN_BASE, 16'h0020, base of the 32-byte MARIA register window.
- MIRROR_MASK, 16'h0300, address bits ignored when matching the window (gives the 0x20/0x120/0x220/0x320 mirrors).
- ZP_BYPASS_NTSC, 16'h0084, ZP reset value when bypass_bios=1 and pal=0.
- ZP_BYPASS_PAL, 16'h2730, ZP reset value when bypass_bios=1 and pal=1.

Ports:
- clk_sys  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mclk0  in  1  master-clock enable; samples CPU phase and commits CTRL.
- pclkp  in  1  CPU-phase level; an access is taken on its 0->1 transition as seen at mclk0.
- maria_en  in  1  0 = 2600 mode: block held in reset state, no decode.
- AB  in  16  CPU address.
- DB_in  in  8  CPU write data.
- RW  in  1  1 = read.
- ABEN  in  1  1 = DMA owns the bus; suppresses decode.
- bypass_bios  in  1  selects bypass ZP reset value.
- pal  in  1  PAL/NTSC select for the ZP bypass value.
- status_read  in  8  MSTAT value returned on reads of offset 0x08.
- line_start  in  1  one-cycle pulse at the start of horizontal blank.
- pal_idx  in  5  colour RAM read index.
- pal_data  out  8  colour RAM word at pal_idx, 1-cycle latency.
- cs_maria  out  1  combinational window hit: (AB & ~MIRROR_MASK)[15:5] == WIN_BASE[15:5] && ~ABEN && maria_en.
- DB_out  out  8  read data, registered.
- ctrl  out  8  committed CTRL.
- char_base  out  8  CHARBASE.
- ZP  out  16  {ZPH, ZPL}.
- wsync  out  1  CPU halt request.

Behaviour:
- Reset (reset=1 or maria_en=0):
  - ctrl = 8'hFF and pending ctrl = 8'hFF (DMA off); all colour RAM = 0.
  - char_base = 0, DB_out = 0, wsync = 0, pal_data = 0, old_phase = 0.
  - ZP = bypass_bios ? (pal ? ZP_BYPASS_PAL : ZP_BYPASS_NTSC) : 0.
- Phase edge: old_phase <= pclkp on each mclk0 cycle. acc = cs_maria && pclkp && ~old_phase && mclk0, so exactly one access strobe per CPU phase. Access decoding uses offset o = AB[4:0].
- Writes (acc && ~RW):
  - 0x04: set wsync.
  - 0x0C: ZPH <= DB_in; 0x10: ZPL <= DB_in; 0x14: char_base <= DB_in; 0x1C: CTRL pending <= DB_in.
  - 0x08 and 0x18: no effect.
  - o == 0: background colour, entry 0.
  - o[1:0] != 0: entry 1 + 3*o[4:2] + (o[1:0] - 1), written only if o[4:2] < NUM_PALETTES; otherwise dropped silently.
- Reads (acc && RW): DB_out <= (o == 0x08) ? status_read : 8'h00; DB_out holds otherwise.
- CTRL commit:
  - ctrl <= pending on any mclk0 cycle with no CTRL write in that cycle, so a new value is visible at the mclk0 after the write strobe (1-mclk0 latency).
  - A CTRL write and a commit in the same cycle: the write wins and the commit defers.
- WSYNC handshake (states IDLE/WAIT):
  - IDLE -> WAIT on a write to 0x04. WAIT -> IDLE on line_start.
  - line_start in the same cycle as a 0x04 write: remain/enter WAIT, i.e. the new request is kept.
  - line_start while IDLE: ignored.
- Colour read port: pal_data <= ram[pal_idx] each cycle. Index >= depth returns 0.
- A write to an entry and a read of the same index in the same cycle returns the old value.
- Reset mid-WAIT: wsync drops in the same reset cycle.

Optional Feature:
- MARIA_REGFILE_READBACK_EN:
  - Defined: reads of 0x0C/0x10/0x14/0x1C return ZPH/ZPL/char_base/pending CTRL. Colour offsets return the stored entry (0 if unimplemented).
  - Undefined: all reads other than 0x08 return 0, matching the stock console.

Test Plan:
- Reset with bypass_bios=1, pal=1 -> ZP=16'h2730, ctrl=8'hFF. With bypass_bios=0 -> ZP=0.
- Write 8'h55 to 0x003C, then idle mclk0 -> ctrl=8'h55 one mclk0 later. pclkp held high across many mclk0 -> only one write taken.
- NUM_PALETTES=2: write 8'hA1 to 0x0021, 8'hB7 to 0x0027, 8'hCC to 0x0031 -> entry1=A1, entry6=B7, 0x0031 dropped. pal_idx=6 -> pal_data=B7 one cycle later.
- Write 0x0024, hold 5 cycles -> wsync=1. line_start pulse -> wsync=0 next cycle. 0x0024 write coincident with line_start -> wsync stays 1.
- Read 0x0128 with status_read=8'h80 -> DB_out=8'h80. Read 0x002C -> DB_out=0, or ZPH with MARIA_REGFILE_READBACK_EN defined.
- ABEN=1 during a write to 0x0030 -> ZPL unchanged, cs_maria=0. maria_en=0 -> ctrl=8'hFF.
